parc_core_reorder_buffer: RTL
=============================

PARC_CORE_REORDER_BUFFER -- requirements
Module: parc_core_reorder_buffer

Interface
REQ-001 SHALL have parameter none; depth fixed at 16 entries, slot index 4 bits.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have these ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rob_alloc_req_val  in  1  decode requests a slot for a register-writing instruction.
- rob_alloc_req_rdy  out  1  a free slot exists.
- rob_alloc_req_preg  in  5  destination architectural register.
- rob_alloc_resp_slot  out  4  slot granted; equals tail pointer.
- rob_fill_val  in  1  writeback delivers a result.
- rob_fill_slot  in  4  slot being filled.
- rob_fill_data  in  32  result value.
- rob_byp0_slot, rob_byp1_slot  in  4 each  scoreboard-selected bypass slots.
- rob_byp0_data, rob_byp1_data  out  32 each  data held in that slot.
- rob_commit_wen  out  1  head entry retires this cycle.
- rob_commit_slot  out  4  slot retiring; equals head pointer.
- rob_commit_rf_waddr  out  5  register-file write address.
- rob_commit_data  out  32  register-file write data.

Function
REQ-004 SHALL keep per entry: valid, ready, preg[4:0], data[31:0]; plus head[3:0], tail[3:0], count[4:0].
REQ-005 SHALL drive rob_alloc_req_rdy = (count != 16), from registered state only.
REQ-006 SHALL, on alloc fire (val && rdy), set entry[tail]: valid=1, ready=0, preg=rob_alloc_req_preg; tail increments mod 16 (15 -> 0).
REQ-007 SHALL drive rob_alloc_resp_slot = tail combinationally, regardless of val.
REQ-008 SHALL, on rob_fill_val with entry[fill_slot].valid=1, set ready=1 and data=rob_fill_data at the next edge; fills to invalid slots SHALL be ignored.
REQ-009 SHALL drive rob_commit_wen = entry[head].valid && entry[head].ready, combinationally from registered state; a fill to head is committed no earlier than the cycle after the fill.
REQ-010 SHALL drive rob_commit_slot = head, rob_commit_rf_waddr = entry[head].preg, rob_commit_data = entry[head].data at all times; consumers qualify with rob_commit_wen.
REQ-011 SHALL, when rob_commit_wen=1, clear entry[head].valid and .ready and increment head mod 16 at the next edge; at most one commit per cycle, strictly in allocation order.
REQ-012 SHALL assert rob_commit_wen for preg=0; suppressing r0 writes is the register file's responsibility.
REQ-013 SHALL update count: +1 on alloc only, -1 on commit only, unchanged on both or neither.
REQ-014 SHALL not allow alloc into the slot committing the same cycle when full; rdy stays 0 that cycle.
REQ-015 SHALL, when alloc and fill target the same slot in one cycle, let the alloc win (ready=0); such a fill is a protocol violation.
REQ-016 SHALL drive rob_bypN_data = entry[rob_bypN_slot].data combinationally; no fill-to-bypass forwarding within the same cycle.
REQ-017 SHALL handle simultaneous alloc, fill, and commit to three distinct slots in one cycle independently.

Reset
REQ-018 SHALL on reset set head=0, tail=0, count=0, all valid/ready=0; outputs: rdy=1, resp_slot=0, commit_wen=0, commit_slot=0.
REQ-019 SHALL on reset asserted mid-operation discard all entries and ignore same-cycle alloc/fill; entry data is not cleared.

Verification
REQ-020 Alloc preg=3 (slot 0), fill slot 0 data 0xDEADBEEF -> next cycle commit_wen=1, slot=0, waddr=3, data=0xDEADBEEF; then count=0.
REQ-021 Alloc slots 0,1,2; fill 2, then 1, then 0 -> commits of 0,1,2 on consecutive cycles, in order, none before slot 0 fills.
REQ-022 16 allocs without fill -> rdy=0, tail=0; fill slot 0 -> commit cycle rdy stays 0; next cycle rdy=1, resp_slot=0.
REQ-023 Wrap: 20 alloc/fill/commit rounds -> slots 0..15,0..3 granted; commit order matches; count never exceeds 16.
REQ-024 Fill slot 5 data 0x1234 with byp0_slot=5 -> byp0_data=0x1234 the following cycle, not the same cycle.
REQ-025 Reset with 4 valid entries -> next cycle count=0, rdy=1, commit_wen=0, resp_slot=0.

Source files
------------

// File: rtl/parc_core_reorder_buffer_if.sv
// Decode/writeback/commit bundle of the 16-entry reorder buffer.
// The master side is the pipeline; the slave side is the ROB itself.
interface parc_core_reorder_buffer_if;
  logic        rob_alloc_req_val;
  logic        rob_alloc_req_rdy;
  logic [4:0]  rob_alloc_req_preg;
  logic [3:0]  rob_alloc_resp_slot;
  logic        rob_fill_val;
  logic [3:0]  rob_fill_slot;
  logic [31:0] rob_fill_data;
  logic [3:0]  rob_byp0_slot;
  logic [3:0]  rob_byp1_slot;
  logic [31:0] rob_byp0_data;
  logic [31:0] rob_byp1_data;
  logic        rob_commit_wen;
  logic [3:0]  rob_commit_slot;
  logic [4:0]  rob_commit_rf_waddr;
  logic [31:0] rob_commit_data;

  modport master (
    output rob_alloc_req_val, rob_alloc_req_preg,
    output rob_fill_val, rob_fill_slot, rob_fill_data,
    output rob_byp0_slot, rob_byp1_slot,
    input  rob_alloc_req_rdy, rob_alloc_resp_slot,
    input  rob_byp0_data, rob_byp1_data,
    input  rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr, rob_commit_data
  );

  modport slave (
    input  rob_alloc_req_val, rob_alloc_req_preg,
    input  rob_fill_val, rob_fill_slot, rob_fill_data,
    input  rob_byp0_slot, rob_byp1_slot,
    output rob_alloc_req_rdy, rob_alloc_resp_slot,
    output rob_byp0_data, rob_byp1_data,
    output rob_commit_wen, rob_commit_slot, rob_commit_rf_waddr, rob_commit_data
  );
endinterface

// File: rtl/parc_core_reorder_buffer.sv
// 16-entry in-order reorder buffer: allocate at tail, fill out of order,
// retire one ready entry per cycle from head.
module parc_core_reorder_buffer (
  input logic                          clk,
  input logic                          reset,
  parc_core_reorder_buffer_if.slave    rob
);
  localparam int DATA_W = 32;
  localparam int PREG_W = 5;
  localparam int DEPTH  = 16;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  ready_q;
  logic [PREG_W-1:0] preg_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [3:0]        head_q;
  logic [3:0]        tail_q;
  logic [4:0]        count_q;

  logic alloc_fire;
  logic fill_fire;
  logic commit_fire;

  assign rob.rob_alloc_req_rdy   = (count_q != 5'd16);
  assign rob.rob_alloc_resp_slot = tail_q;

  assign alloc_fire  = rob.rob_alloc_req_val && rob.rob_alloc_req_rdy;
  assign commit_fire = valid_q[head_q] && ready_q[head_q];
  // A fill aimed at the entry retiring this cycle would resurrect a freed slot.
  assign fill_fire   = rob.rob_fill_val && valid_q[rob.rob_fill_slot] &&
                       !(commit_fire && (rob.rob_fill_slot == head_q)) && !reset;

  assign rob.rob_commit_wen      = commit_fire;
  assign rob.rob_commit_slot     = head_q;
  assign rob.rob_commit_rf_waddr = preg_q[head_q];
  assign rob.rob_commit_data     = data_q[head_q];
  assign rob.rob_byp0_data       = data_q[rob.rob_byp0_slot];
  assign rob.rob_byp1_data       = data_q[rob.rob_byp1_slot];

  // Control state: pointers, occupancy and per-entry valid/ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= 4'd0;
      tail_q  <= 4'd0;
      count_q <= 5'd0;
    end else begin
      if (commit_fire) begin
        valid_q[head_q] <= 1'b0;
        ready_q[head_q] <= 1'b0;
        head_q          <= head_q + 4'd1;
      end
      if (fill_fire) begin
        ready_q[rob.rob_fill_slot] <= 1'b1;
      end
      // Alloc is applied last so it wins over a same-slot fill.
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        ready_q[tail_q] <= 1'b0;
        tail_q          <= tail_q + 4'd1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload state: never reset, written only by accepted alloc/fill.
  always_ff @(posedge clk) begin
    if (alloc_fire && !reset) begin
      preg_q[tail_q] <= rob.rob_alloc_req_preg;
    end
    if (fill_fire) begin
      data_q[rob.rob_fill_slot] <= rob.rob_fill_data;
    end
  end
endmodule
